// File: rtl/net_input_loader_pkg.sv
// Shared types and sizes for the network input loader.
// Frame size defaults to the network's input layer width.
package net_input_loader_pkg;

  localparam int NET_INPUT_SIZE = 784;
  localparam int BYTE_W         = 8;
  localparam int IDX_W          = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_DRAIN,
    ST_START,
    ST_WAIT,
    ST_REPORT
  } loader_state_t;

endpackage

// File: rtl/net_input_loader_if.sv
// Pixel stream and classification result handshakes of the network input loader.
// master = stream source / result consumer, slave = the loader.
interface net_input_loader_if;
  import net_input_loader_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [BYTE_W-1:0] in_data;
  logic              in_last;
  logic              res_valid;
  logic              res_ready;
  logic [IDX_W-1:0]  res_idx;
  logic              res_err;

  modport master (
    output in_valid, in_data, in_last, res_ready,
    input  in_ready, res_valid, res_idx, res_err
  );

  modport slave (
    input  in_valid, in_data, in_last, res_ready,
    output in_ready, res_valid, res_idx, res_err
  );

endinterface

// File: rtl/net_input_loader_timeout.sv
// Loadable idle down-counter; expired is high while the count sits at zero.
// Only built when NET_LOADER_TIMEOUT_EN is defined.
`ifdef NET_LOADER_TIMEOUT_EN
module loader_timeout #(
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= TO_W'(TIMEOUT_CYCLES - 1);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule
`endif

// File: rtl/net_input_loader.sv
// Front-end loader: clears processor data memory, streams one frame into it, starts the
// processor and reports its class index. Optional idle timeout under NET_LOADER_TIMEOUT_EN.
module net_input_loader
  import net_input_loader_pkg::*;
#(
  parameter int NUM_PIXELS = NET_INPUT_SIZE,
  parameter int CNT_W      = $clog2(NUM_PIXELS + 1)
`ifdef NET_LOADER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 2**20
`endif
) (
  input  logic              clk,
  input  logic              rst,
  net_input_loader_if.slave bus,
  output logic              busy,
  output logic              net_start,
  input  logic              net_done,
  input  logic [IDX_W-1:0]  net_max_idx,
  output logic              ext_mem_rst,
  output logic              ext_mem_we,
  output logic [BYTE_W-1:0] ext_mem_wdata
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PIXELS - 1);

  loader_state_t    state;
  logic [CNT_W-1:0] pix_cnt;
  logic [IDX_W-1:0] res_idx_q;
  logic             res_err_q;
  logic             wait_armed;
  logic             in_ready;
  logic             hs;
  logic             timeout_hit;

  assign in_ready = (state == ST_LOAD) || (state == ST_DRAIN);
  assign hs       = bus.in_valid && in_ready;

  // Outputs are pure decodes of the state register, except the zero-latency write path.
  assign bus.in_ready  = in_ready;
  assign bus.res_valid = (state == ST_REPORT);
  assign bus.res_idx   = res_idx_q;
  assign bus.res_err   = res_err_q;
  assign busy          = (state != ST_IDLE);
  assign net_start     = (state == ST_START);
  assign ext_mem_rst   = (state == ST_CLEAR);
  assign ext_mem_we    = (state == ST_LOAD) && hs;
  assign ext_mem_wdata = ext_mem_we ? bus.in_data : '0;

`ifdef NET_LOADER_TIMEOUT_EN
  logic to_load;
  logic to_en;

  assign to_load = (state == ST_CLEAR) || (state == ST_START) || hs;
  assign to_en   = (state == ST_LOAD) || (state == ST_DRAIN) || (state == ST_WAIT);

  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .load    (to_load),
    .en      (to_en),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pix_cnt    <= '0;
      res_idx_q  <= '0;
      res_err_q  <= 1'b0;
      wait_armed <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) state <= ST_CLEAR;
        end
        ST_CLEAR: begin
          pix_cnt <= '0;
          state   <= ST_LOAD;
        end
        ST_LOAD: begin
          if (hs) begin
            pix_cnt <= pix_cnt + 1'b1;
            if (pix_cnt == LAST_CNT) begin
              if (bus.in_last) begin
                state <= ST_START;
              end else begin
                state     <= ST_DRAIN;
                res_err_q <= 1'b1;
                res_idx_q <= '0;
              end
            end else if (bus.in_last) begin
              state     <= ST_REPORT;
              res_err_q <= 1'b1;
              res_idx_q <= '0;
            end
          end else if (timeout_hit) begin
            state     <= ST_REPORT;
            res_err_q <= 1'b1;
            res_idx_q <= '0;
          end
        end
        // Oversized frame: swallow the tail so the next frame starts aligned.
        ST_DRAIN: begin
          if ((hs && bus.in_last) || (!hs && timeout_hit)) begin
            state     <= ST_REPORT;
            res_err_q <= 1'b1;
            res_idx_q <= '0;
          end
        end
        ST_START: begin
          wait_armed <= 1'b0;
          state      <= ST_WAIT;
        end
        // net_done may still be high from the previous run during the first WAIT cycle.
        ST_WAIT: begin
          if (!wait_armed) begin
            wait_armed <= 1'b1;
          end else if (net_done) begin
            res_idx_q <= net_max_idx;
            res_err_q <= 1'b0;
            state     <= ST_REPORT;
          end else if (timeout_hit) begin
            res_idx_q <= '0;
            res_err_q <= 1'b1;
            state     <= ST_REPORT;
          end
        end
        ST_REPORT: begin
          if (bus.res_ready) begin
            state     <= ST_IDLE;
            res_idx_q <= '0;
            res_err_q <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_net_input_loader.sv
// Directed bench for net_input_loader with a behavioural processor model.
`timescale 1ns/1ps
module tb_net_input_loader;
  import net_input_loader_pkg::*;

`ifdef NET_LOADER_TIMEOUT_EN
  localparam int MDL_LAT = 10;
`else
  localparam int MDL_LAT = 50;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  net_input_loader_if bus();
  logic       busy, net_start, ext_mem_rst, ext_mem_we;
  logic [7:0] ext_mem_wdata;
  logic       net_done = 1'b0;
  logic [3:0] net_max_idx = 4'd0;
  logic [3:0] mdl_idx = 4'd0;

  net_input_loader #(
    .NUM_PIXELS(784)
`ifdef NET_LOADER_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .busy          (busy),
    .net_start     (net_start),
    .net_done      (net_done),
    .net_max_idx   (net_max_idx),
    .ext_mem_rst   (ext_mem_rst),
    .ext_mem_we    (ext_mem_we),
    .ext_mem_wdata (ext_mem_wdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Processor model: done drops two cycles after start, rises MDL_LAT cycles after start.
  int mdl_cnt  = 0;
  int mdl_drop = 0;
  always @(negedge clk) begin
    if (net_start) begin
      mdl_cnt  = MDL_LAT;
      mdl_drop = 2;
    end else begin
      if (mdl_drop != 0) begin
        mdl_drop--;
        if (mdl_drop == 0) net_done = 1'b0;
      end
      if (mdl_cnt != 0) begin
        mdl_cnt--;
        if (mdl_cnt == 0) begin
          net_done    = 1'b1;
          net_max_idx = mdl_idx;
        end
      end
    end
  end

  // Write monitor: byte k of every frame is k % 256.
  logic mon_clr = 1'b0;
  int we_cnt = 0, rst_cnt = 0, start_cnt = 0, bad_data = 0, we_wo_ready = 0;
  always @(negedge clk) begin
    if (mon_clr) begin
      we_cnt = 0; rst_cnt = 0; start_cnt = 0; bad_data = 0; we_wo_ready = 0;
    end else begin
      if (ext_mem_we) begin
        if (ext_mem_wdata !== 8'(we_cnt % 256)) bad_data++;
        if (bus.in_ready !== 1'b1) we_wo_ready++;
        we_cnt++;
      end
      if (ext_mem_rst) rst_cnt++;
      if (net_start) start_cnt++;
    end
  end

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0;
  endtask

  task automatic send_frame(input int n, input int last_at, input bit gaps, output int stalls);
    int g;
    bit hs;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        repeat (g) begin @(posedge clk); #1; end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i % 256);
      bus.in_last  = (i == last_at);
      hs = 1'b0;
      for (int t = 0; t < 64 && !hs; t++) begin
        @(negedge clk);
        hs = bus.in_ready;
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      if (!hs) begin
        stalls++;
        break;
      end
    end
  endtask

  task automatic wait_result(input int max_cyc, output int cyc, output bit got);
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < max_cyc) begin
      @(negedge clk);
      if (bus.res_valid === 1'b1) got = 1'b1;
      else begin
        cyc++;
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic accept_result();
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.in_ready, bus.res_valid, bus.res_err, busy, net_start, ext_mem_rst, ext_mem_we} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {bus.in_ready, bus.res_valid, bus.res_err, busy, net_start, ext_mem_rst, ext_mem_we});
    end
    n_checks++;
    if (bus.res_idx !== 4'd0) begin n_fail++; $display("FAIL reset_idx: got %0d expected 0", bus.res_idx); end
    n_checks++;
    if (ext_mem_wdata !== 8'd0) begin n_fail++; $display("FAIL reset_wdata: got %0d expected 0", ext_mem_wdata); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_full_frame();
    int stalls, cyc;
    bit got;
    mdl_idx = 4'd7;
    clear_mon();
    send_frame(784, 783, 1'b0, stalls);
    wait_result(MDL_LAT + 40, cyc, got);
    n_checks++;
    if (!got || stalls != 0) begin n_fail++; $display("FAIL full_result: got valid=%0d stalls=%0d expected valid=1 stalls=0", got, stalls); end
    n_checks++;
    if (bus.res_idx !== 4'd7) begin n_fail++; $display("FAIL full_idx: got %0d expected 7", bus.res_idx); end
    n_checks++;
    if (bus.res_err !== 1'b0) begin n_fail++; $display("FAIL full_err: got %0d expected 0", bus.res_err); end
    n_checks++;
    if (we_cnt != 784) begin n_fail++; $display("FAIL full_we_cnt: got %0d expected 784", we_cnt); end
    n_checks++;
    if (bad_data != 0 || we_wo_ready != 0) begin n_fail++; $display("FAIL full_data: got %0d bad bytes, %0d unhandshaked expected 0", bad_data, we_wo_ready); end
    n_checks++;
    if (rst_cnt != 1 || start_cnt != 1) begin n_fail++; $display("FAIL full_pulses: got mem_rst=%0d start=%0d expected 1 and 1", rst_cnt, start_cnt); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy_report: got %0d expected 1", busy); end
    accept_result();
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL full_idle: got busy=%0d valid=%0d expected 0 0", busy, bus.res_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int stalls, cyc, unstable;
    bit got;
    mdl_idx = 4'd4;
    clear_mon();
    send_frame(784, 783, 1'b1, stalls);
    wait_result(MDL_LAT + 40, cyc, got);
    n_checks++;
    if (!got || stalls != 0) begin n_fail++; $display("FAIL bp_result: got valid=%0d stalls=%0d expected valid=1 stalls=0", got, stalls); end
    n_checks++;
    if (we_cnt != 784 || bad_data != 0) begin n_fail++; $display("FAIL bp_writes: got %0d writes %0d bad expected 784 0", we_cnt, bad_data); end
    unstable = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b1 || bus.res_idx !== 4'd4 || bus.res_err !== 1'b0) unstable++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (unstable != 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", unstable); end
    accept_result();
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got busy=%0d expected 0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_short_frame();
    int stalls, cyc;
    bit got;
    clear_mon();
    send_frame(101, 100, 1'b0, stalls);
    wait_result(20, cyc, got);
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL short_result: got valid=0 expected 1"); end
    n_checks++;
    if (we_cnt != 101 || bad_data != 0) begin n_fail++; $display("FAIL short_writes: got %0d writes %0d bad expected 101 0", we_cnt, bad_data); end
    n_checks++;
    if (start_cnt != 0) begin n_fail++; $display("FAIL short_start: got %0d expected 0", start_cnt); end
    n_checks++;
    if (bus.res_err !== 1'b1 || bus.res_idx !== 4'd0) begin n_fail++; $display("FAIL short_err: got err=%0d idx=%0d expected 1 0", bus.res_err, bus.res_idx); end
    accept_result();
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL short_idle: got busy=%0d expected 0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_long_frame();
    int stalls, cyc;
    bit got;
    clear_mon();
    send_frame(790, 789, 1'b0, stalls);
    wait_result(20, cyc, got);
    n_checks++;
    if (!got || stalls != 0) begin n_fail++; $display("FAIL long_result: got valid=%0d stalls=%0d expected 1 0", got, stalls); end
    n_checks++;
    if (we_cnt != 784 || bad_data != 0) begin n_fail++; $display("FAIL long_writes: got %0d writes %0d bad expected 784 0", we_cnt, bad_data); end
    n_checks++;
    if (start_cnt != 0) begin n_fail++; $display("FAIL long_start: got %0d expected 0", start_cnt); end
    n_checks++;
    if (bus.res_err !== 1'b1 || bus.res_idx !== 4'd0) begin n_fail++; $display("FAIL long_err: got err=%0d idx=%0d expected 1 0", bus.res_err, bus.res_idx); end
    accept_result();
    @(posedge clk); #1;
  endtask

  task automatic test_stale_done();
    int stalls, cyc;
    bit got;
    mdl_idx = 4'd3;
    clear_mon();
    send_frame(784, 783, 1'b0, stalls);
    wait_result(MDL_LAT + 40, cyc, got);
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL stale_result: got valid=0 expected 1"); end
    n_checks++;
    if (cyc < MDL_LAT - 5) begin n_fail++; $display("FAIL stale_latency: got %0d cycles expected at least %0d", cyc, MDL_LAT - 5); end
    n_checks++;
    if (bus.res_idx !== 4'd3) begin n_fail++; $display("FAIL stale_idx: got %0d expected 3", bus.res_idx); end
    accept_result();
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    int stalls;
    clear_mon();
    send_frame(300, -1, 1'b0, stalls);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, bus.in_ready, ext_mem_we, bus.res_valid, net_start} !== 5'b0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got %b expected 00000", {busy, bus.in_ready, ext_mem_we, bus.res_valid, net_start});
    end
    n_checks++;
    if (we_cnt != 300) begin n_fail++; $display("FAIL midrst_writes: got %0d expected 300", we_cnt); end
    repeat (100) @(posedge clk);
    #1;
    n_checks++;
    if (start_cnt != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_quiet: got start=%0d busy=%0d expected 0 0", start_cnt, busy); end
  endtask

`ifdef NET_LOADER_TIMEOUT_EN
  task automatic test_timeout();
    int stalls, cyc;
    bit got;
    clear_mon();
    send_frame(10, -1, 1'b0, stalls);
    wait_result(40, cyc, got);
    n_checks++;
    if (!got || bus.res_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got valid=%0d err=%0d expected 1 1", got, bus.res_err); end
    n_checks++;
    if (cyc < 14 || we_cnt != 10 || start_cnt != 0) begin
      n_fail++;
      $display("FAIL timeout_shape: got cyc=%0d writes=%0d start=%0d expected cyc>=14 10 0", cyc, we_cnt, start_cnt);
    end
    accept_result();
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'd0;
    bus.in_last   = 1'b0;
    bus.res_ready = 1'b0;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_short_frame();
    test_long_frame();
    test_stale_done();
    test_mid_reset();
`ifdef NET_LOADER_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
